aes_encrypt_iter: RTL and testbench

Iterative AES-128 encryption core: one round per clock, forward ShiftRows/MixColumns/SubBytes/AddRoundKey. It is the cipher-direction counterpart of the decryption datapath and uses the same state byte mapping. Round keys come from an external key-expansion store through a combinational index/key port. Blocks enter and leave over valid/ready handshakes.

---
 rtl/aes_encrypt_iter.sv | 103 ++++++++++
 tb/tb_aes_encrypt_iter.sv | 190 +++++++++++++++++++
 2 files changed

// File: rtl/aes_encrypt_iter.sv
// aes_encrypt_iter: iterative AES-128 encryption core, one round per clock, external round-key port.
// Optional AES_ENC_SELFCLEAR_EN clears the state register on the output handshake.
module sbox (
   input  logic [7:0] a,
   output logic [7:0] y
);
   localparam logic [2047:0] TAB = {
      128'h637c777bf26b6fc53001672bfed7ab76, 128'hca82c97dfa5947f0add4a2af9ca472c0,
      128'hb7fd9326363ff7cc34a5e5f171d83115, 128'h04c723c31896059a071280e2eb27b275,
      128'h09832c1a1b6e5aa0523bd6b329e32f84, 128'h53d100ed20fcb15b6acbbe394a4c58cf,
      128'hd0efaafb434d338545f9027f503c9fa8, 128'h51a3408f929d38f5bcb6da2110fff3d2,
      128'hcd0c13ec5f974417c4a77e3d645d1973, 128'h60814fdc222a908846eeb814de5e0bdb,
      128'he0323a0a4906245cc2d3ac629195e479, 128'he7c8376d8dd54ea96c56f4ea657aae08,
      128'hba78252e1ca6b4c6e8dd741f4bbd8b8a, 128'h703eb5664803f60e613557b986c11d9e,
      128'he1f8981169d98e949b1e87e9ce5528df, 128'h8ca1890dbfe6426841992d0fb054bb16};
   // entry 0 sits in the top byte, so index from the top with ~a
   assign y = TAB[{~a, 3'b000} +: 8];
endmodule

module aes_encrypt_iter (
   input  logic         clk,
   input  logic         rst_n,
   input  logic         in_valid,
   output logic         in_ready,
   input  logic [127:0] in_data,
   output logic [3:0]   rk_idx,
   input  logic [127:0] rk,
   output logic         out_valid,
   input  logic         out_ready,
   output logic [127:0] out_data
);
   typedef enum logic [1:0] {IDLE, ROUND, DONE} st_t;
   st_t st, st_n;
   logic [3:0] round, round_n;
   logic [127:0] state, state_n, sb, sr, mc;

   function automatic logic [7:0] xt(input logic [7:0] b);
      return {b[6:0], 1'b0} ^ (b[7] ? 8'h1b : 8'h00);
   endfunction

   function automatic logic [31:0] mix_col(input logic [31:0] col);
      logic [7:0] a0, a1, a2, a3;
      {a3, a2, a1, a0} = col;
      return {xt(a0) ^ a0 ^ a1 ^ a2 ^ xt(a3),
              a0 ^ a1 ^ xt(a2) ^ xt(a3) ^ a3,
              a0 ^ xt(a1) ^ xt(a2) ^ a2 ^ a3,
              xt(a0) ^ xt(a1) ^ a1 ^ a2 ^ a3};
   endfunction

   for (genvar i = 0; i < 16; i++) begin : g_sb
      sbox u_sbox (.a(state[8*i +: 8]), .y(sb[8*i +: 8]));
   end

   for (genvar c = 0; c < 4; c++) begin : g_col
      for (genvar r = 0; r < 4; r++) begin : g_row
         assign sr[32*c + 8*r +: 8] = sb[32*((c + r) % 4) + 8*r +: 8];
      end
      assign mc[32*c +: 32] = mix_col(sr[32*c +: 32]);
   end

   always_comb begin
      st_n = st;
      round_n = round;
      state_n = state;
      in_ready = st == IDLE;
      out_valid = st == DONE;
      rk_idx = st == ROUND ? round : 4'd0;
      case (st)
         IDLE: if (in_valid) begin
            state_n = in_data ^ rk;
            round_n = 4'd1;
            st_n = ROUND;
         end
         ROUND: begin
            state_n = (round >= 4'd10 ? sr : mc) ^ rk;
            // the last round skips MixColumns and ends unconditionally, so round never passes 10
            if (round >= 4'd10) st_n = DONE;
            else round_n = round + 4'd1;
         end
         DONE: if (out_ready) begin
            st_n = IDLE;
`ifdef AES_ENC_SELFCLEAR_EN
            state_n = '0;
`endif
         end
         default: st_n = IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         st <= IDLE;
         round <= '0;
         state <= '0;
      end else begin
         st <= st_n;
         round <= round_n;
         state <= state_n;
      end
   end

   assign out_data = state;
endmodule

// File: tb/tb_aes_encrypt_iter.sv
// tb_aes_encrypt_iter: directed FIPS-197 vectors, handshake, backpressure and reset-abort checks.
module tb_aes_encrypt_iter;
   logic clk = 0, rst_n = 0, in_valid = 0, out_ready = 0, out_valid, in_ready, sel = 0;
   logic [127:0] in_data = '0, rk, out_data;
   logic [3:0] rk_idx;
   logic [127:0] rkb [0:15], rkc [0:15];
   int total = 0, bad = 0, cyc = 0;
   int acc[$];

   localparam logic [2047:0] SB = {
      128'h637c777bf26b6fc53001672bfed7ab76, 128'hca82c97dfa5947f0add4a2af9ca472c0,
      128'hb7fd9326363ff7cc34a5e5f171d83115, 128'h04c723c31896059a071280e2eb27b275,
      128'h09832c1a1b6e5aa0523bd6b329e32f84, 128'h53d100ed20fcb15b6acbbe394a4c58cf,
      128'hd0efaafb434d338545f9027f503c9fa8, 128'h51a3408f929d38f5bcb6da2110fff3d2,
      128'hcd0c13ec5f974417c4a77e3d645d1973, 128'h60814fdc222a908846eeb814de5e0bdb,
      128'he0323a0a4906245cc2d3ac629195e479, 128'he7c8376d8dd54ea96c56f4ea657aae08,
      128'hba78252e1ca6b4c6e8dd741f4bbd8b8a, 128'h703eb5664803f60e613557b986c11d9e,
      128'he1f8981169d98e949b1e87e9ce5528df, 128'h8ca1890dbfe6426841992d0fb054bb16};

   aes_encrypt_iter dut (
      .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data),
      .rk_idx(rk_idx), .rk(rk), .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data)
   );

   always #5 clk = ~clk;
   always @(posedge clk) cyc <= cyc + 1;
   always @(negedge clk) if (in_valid && in_ready) acc.push_back(cyc);
   assign rk = sel ? rkc[rk_idx] : rkb[rk_idx];

   function automatic logic [127:0] rev(input logic [127:0] x);
      logic [127:0] y;
      for (int i = 0; i < 16; i++) y[8*i +: 8] = x[8*(15-i) +: 8];
      return y;
   endfunction

   function automatic logic [31:0] sub_word(input logic [31:0] w);
      logic [31:0] y;
      for (int i = 0; i < 4; i++) y[8*i +: 8] = SB[{~w[8*i +: 8], 3'b000} +: 8];
      return y;
   endfunction

   // FIPS-197 key expansion in big-endian word order, then remapped to the core's byte layout
   function automatic logic [127:0] round_key(input logic [127:0] key, input int k);
      logic [31:0] w [0:43];
      logic [31:0] t;
      logic [7:0] rc;
      rc = 8'h01;
      for (int i = 0; i < 4; i++) w[i] = key[127-32*i -: 32];
      for (int i = 4; i < 44; i++) begin
         t = w[i-1];
         if (i % 4 == 0) begin
            t = sub_word({t[23:0], t[31:24]}) ^ {rc, 24'h0};
            rc = {rc[6:0], 1'b0} ^ (rc[7] ? 8'h1b : 8'h00);
         end
         w[i] = w[i-4] ^ t;
      end
      return rev({w[4*k], w[4*k+1], w[4*k+2], w[4*k+3]});
   endfunction

   task automatic check(input string tag, input logic [127:0] got, input logic [127:0] exp);
      total++;
      if (got !== exp) begin
         bad++;
         $display("FAIL %s: got %h expected %h", tag, got, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic run_block(input logic s, input logic [127:0] pt, input logic [127:0] ct);
      int n;
      logic idx_ok;
      sel = s;
      in_data = pt;
      in_valid = 1;
      check("idle_ready", in_ready, 1);
      check("idle_idx", rk_idx, 0);
      tick();
      in_valid = 0;
      n = 0;
      idx_ok = 1;
      while (!out_valid && n < 20) begin
         if (rk_idx != 4'(n + 1)) idx_ok = 0;
         tick();
         n++;
      end
      check("latency", n, 10);
      check("idx_seq", idx_ok, 1);
      check("ct", out_data, ct);
   endtask

   logic [127:0] pt_b, ct_b, pt_c, ct_c;
   int n;

   initial begin
      pt_b = rev(128'h3243f6a8885a308d313198a2e0370734);
      ct_b = rev(128'h3925841d02dc09fbdc118597196a0b32);
      pt_c = rev(128'h00112233445566778899aabbccddeeff);
      ct_c = rev(128'h69c4e0d86a7b0430d8cdb78070b4c55a);
      for (int k = 0; k < 16; k++) begin
         rkb[k] = k <= 10 ? round_key(128'h2b7e151628aed2a6abf7158809cf4f3c, k) : '0;
         rkc[k] = k <= 10 ? round_key(128'h000102030405060708090a0b0c0d0e0f, k) : '0;
      end
      repeat (2) @(posedge clk);
      #1;
      check("rst_ready", in_ready, 1);
      check("rst_valid", out_valid, 0);
      check("rst_data", out_data, 0);
      check("rst_idx", rk_idx, 0);
      rst_n = 1;
      tick();

      run_block(0, pt_b, ct_b);
      for (int i = 0; i < 5; i++) begin
         check("bp_valid", out_valid, 1);
         check("bp_data", out_data, ct_b);
         check("bp_ready", in_ready, 0);
         in_valid = i == 2;
         in_data = 128'hdeadbeef;
         tick();
      end
      in_valid = 0;
      out_ready = 1;
      tick();
      out_ready = 0;
      check("hs_ready", in_ready, 1);
      check("hs_valid", out_valid, 0);
`ifdef AES_ENC_SELFCLEAR_EN
      check("hs_data", out_data, 0);
`else
      check("hs_data", out_data, ct_b);
`endif
      tick();
      check("pulse_ignored", in_ready, 1);

      run_block(1, pt_c, ct_c);
      out_ready = 1;
      tick();
      out_ready = 0;

      acc.delete();
      sel = 0;
      in_data = pt_b;
      in_valid = 1;
      out_ready = 1;
      n = 0;
      tick();
      while (!out_valid && n < 30) begin tick(); n++; end
      check("b2b_ct1", out_data, ct_b);
      sel = 1;
      in_data = pt_c;
      tick();
      n = 0;
      while (!out_valid && n < 30) begin tick(); n++; end
      check("b2b_ct2", out_data, ct_c);
      in_valid = 0;
      tick();
      out_ready = 0;
      check("b2b_accepts", acc.size(), 2);
      if (acc.size() >= 2) check("b2b_spacing", acc[1] - acc[0], 12);

      sel = 0;
      in_data = pt_b;
      in_valid = 1;
      tick();
      in_valid = 0;
      repeat (4) tick();
      check("mid_idx", rk_idx, 5);
      rst_n = 0;
      #1;
      check("abort_valid", out_valid, 0);
      check("abort_data", out_data, 0);
      check("abort_ready", in_ready, 1);
      tick();
      rst_n = 1;
      tick();
      check("post_ready", in_ready, 1);
      check("post_valid", out_valid, 0);
      run_block(0, pt_b, ct_b);
      out_ready = 1;
      tick();
      out_ready = 0;

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end
endmodule
